axi_lite_master_engine: RTL and testbench
=========================================

Name: axi_lite_master_engine

Overview:
AXI4-Lite master that sits directly upstream of the s3 AXI-Lite register slave (wrapper) and drives its five channels. A simple command/response port is converted into single, non-overlapping AXI-Lite write or read transactions. The engine holds every valid stable until its handshake, sequences the write response and read data, and flags a stalled slave through a timeout. It replaces hand-driven bench stimulus and is the bus master for a future CPU/DMA front end.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8.
ADDR_WIDTH, 8, byte address width.
RESP_WIDTH, 3, response field width to match the slave; bits [1:0] carry the AXI code and upper bits are driven 0 / ignored.
TIMEOUT_CYCLES, 256, maximum wait cycles in any bus state; 0 disables the timeout.

Ports:
s3_axi_aclk  in  1  clock
s3_axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  RESP_WIDTH  bresp/rresp captured
rsp_timeout  out  1  transaction aborted by timeout
busy  out  1  state != IDLE
m3_axi_awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  write address channel
m3_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
m3_axi_bresp/bvalid/bready  in/in/out  RESP_WIDTH/1/1  write response channel
m3_axi_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  read address channel
m3_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/RESP_WIDTH/1/1  read data channel

Behaviour:
- Reset (async assert, sync release): state=IDLE; all valids, bready, rready, rsp_valid, rsp_timeout = 0; addr/data/resp registers = 0; cmd_ready=1 after release.
- cmd_ready = (state==IDLE). Command accepted on cmd_valid & cmd_ready at edge N; addr/data/strb captured into registers; AXI outputs are driven only from those registers.
- Write states:
  - WR_AD: from edge N, awvalid=wvalid=1. Each drops independently on its own handshake (awready / wready may arrive in either order or the same cycle).
  - When both handshakes are done, go to WR_B with bready=1.
  - bvalid & bready: capture bresp, bready=0, go to RSP.
- Read states:
  - RD_A: arvalid=1 until arready.
  - RD_D: rready=1. On rvalid, capture rdata/rresp, go to RSP.
- RSP: rsp_valid=1 and the response fields are stable. rsp_valid & rsp_ready moves to IDLE (cmd_ready=1 the next cycle).
- Minimum latency with a zero-wait slave: write accept N, aw/w handshake N+1, b handshake N+2, rsp_valid N+3. The read path is the same.
- Valids never depend on readies combinationally. Addr/data are stable while valid is high.
- Timeout counter:
  - Cleared on every state entry; increments each cycle in WR_AD/WR_B/RD_A/RD_D.
  - At TIMEOUT_CYCLES-1 without completion: all valids/readies drop the next edge, go to RSP with rsp_timeout=1, rsp_resp=2'b10 (SLVERR), rsp_rdata=0.
  - Abort is a recovery-only protocol exception.
- rsp_timeout=0 for normal completion. The SLVERR/DECERR codes from the slave pass through unchanged.
- cmd_valid is ignored outside IDLE. Only one transaction is outstanding at any time.
- Reset mid-transaction: outputs go to reset values immediately; the captured command is discarded.

Decomposition:
- axi_lite_pkg holds:
  - response codes OKAY/EXOKAY/SLVERR/DECERR;
  - state encoding IDLE, WR_AD, WR_B, RD_A, RD_D, RSP;
  - a helper for strobe width (DATA_WIDTH/8).
- One sub-module, axi_lite_timeout_ctr: clear, enable, and expired outputs, with a width derived from TIMEOUT_CYCLES. It is bypassed when TIMEOUT_CYCLES=0.
- The FSM and datapath live in the top level.

Test Plan:
- Write addr 0x00 data 25 strb 0xF against the wrapper, zero-wait -> aw/w handshake N+1, rsp_valid N+3, rsp_resp=0, rsp_timeout=0.
- Write addr 0x04 data 34, then read 0x00 and 0x04 -> rsp_rdata 25 then 34, rresp=0.
- Slave stub gives wready 3 cycles before awready (and the reverse) -> wvalid drops after its handshake, awvalid is held; exactly one write occurs with correct data.
- rsp_ready held low 5 cycles after a read of 0x04 -> rsp_valid/rsp_rdata=34 stable, cmd_ready=0 until consumed.
- Stub never asserts bvalid, TIMEOUT_CYCLES=16 -> bready drops, rsp_valid with rsp_timeout=1 and rsp_resp=2, returns to IDLE.
- aresetn pulsed low while awvalid=1 -> awvalid/wvalid fall asynchronously; after release cmd_ready=1 and the next write of 0x08/7 completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, engine states and strobe-width helper
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AD,
        ST_WR_B,
        ST_RD_A,
        ST_RD_D,
        ST_RSP
    } state_e;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// rtl/axi_lite_timeout_ctr.sv - per-state wait counter; expired on the last allowed cycle
module axi_lite_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clear, enable};
            assign expired       = 1'b0;
        end else begin : g_ctr
            localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

            logic [W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && !expired) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = enable && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/axi_lite_master_engine.sv
// rtl/axi_lite_master_engine.sv - command/response port to single AXI4-Lite transactions
// One transaction outstanding; stalled slaves are aborted to a SLVERR/timeout response.
module axi_lite_master_engine
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int RESP_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                s3_axi_aclk,
    input  logic                                s3_axi_aresetn,

    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [ADDR_WIDTH-1:0]               cmd_addr,
    input  logic [DATA_WIDTH-1:0]               cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]   cmd_wstrb,

    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic [RESP_WIDTH-1:0]               rsp_resp,
    output logic                                rsp_timeout,
    output logic                                busy,

    output logic [ADDR_WIDTH-1:0]               m3_axi_awaddr,
    output logic                                m3_axi_awvalid,
    input  logic                                m3_axi_awready,
    output logic [DATA_WIDTH-1:0]               m3_axi_wdata,
    output logic [strb_width(DATA_WIDTH)-1:0]   m3_axi_wstrb,
    output logic                                m3_axi_wvalid,
    input  logic                                m3_axi_wready,
    input  logic [RESP_WIDTH-1:0]               m3_axi_bresp,
    input  logic                                m3_axi_bvalid,
    output logic                                m3_axi_bready,
    output logic [ADDR_WIDTH-1:0]               m3_axi_araddr,
    output logic                                m3_axi_arvalid,
    input  logic                                m3_axi_arready,
    input  logic [DATA_WIDTH-1:0]               m3_axi_rdata,
    input  logic [RESP_WIDTH-1:0]               m3_axi_rresp,
    input  logic                                m3_axi_rvalid,
    output logic                                m3_axi_rready
);

    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

    function automatic logic [RESP_WIDTH-1:0] resp_field(input logic [1:0] code);
        resp_field      = '0;
        resp_field[1:0] = code;
    endfunction

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, ad_done;
    logic completing, tmo_en, tmo_clr, tmo_expired, abort;
    logic unused_resp_bits;

    assign aw_hs   = m3_axi_awvalid & m3_axi_awready;
    assign w_hs    = m3_axi_wvalid  & m3_axi_wready;
    assign ar_hs   = m3_axi_arvalid & m3_axi_arready;
    assign b_hs    = m3_axi_bvalid  & m3_axi_bready;
    assign r_hs    = m3_axi_rvalid  & m3_axi_rready;
    // Each write channel is done once its valid has already dropped or handshakes now.
    assign ad_done = (!m3_axi_awvalid | m3_axi_awready) & (!m3_axi_wvalid | m3_axi_wready);

    assign completing = ((state == ST_WR_AD) & ad_done) |
                        ((state == ST_WR_B)  & b_hs)    |
                        ((state == ST_RD_A)  & ar_hs)   |
                        ((state == ST_RD_D)  & r_hs);
    assign tmo_en  = (state == ST_WR_AD) | (state == ST_WR_B) |
                     (state == ST_RD_A)  | (state == ST_RD_D);
    assign tmo_clr = !tmo_en | completing;
    assign abort   = tmo_expired & !completing;

    assign unused_resp_bits = ^{m3_axi_bresp, m3_axi_rresp};

    axi_lite_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (s3_axi_aclk),
        .rst_n   (s3_axi_aresetn),
        .clear   (tmo_clr),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign m3_axi_awaddr = addr_q;
    assign m3_axi_araddr = addr_q;
    assign m3_axi_wdata  = wdata_q;
    assign m3_axi_wstrb  = wstrb_q;

    always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
        if (!s3_axi_aresetn) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            m3_axi_awvalid <= 1'b0;
            m3_axi_wvalid  <= 1'b0;
            m3_axi_bready  <= 1'b0;
            m3_axi_arvalid <= 1'b0;
            m3_axi_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= '0;
            rsp_timeout    <= 1'b0;
        end else if (abort) begin
            m3_axi_awvalid <= 1'b0;
            m3_axi_wvalid  <= 1'b0;
            m3_axi_bready  <= 1'b0;
            m3_axi_arvalid <= 1'b0;
            m3_axi_rready  <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_timeout    <= 1'b1;
            rsp_resp       <= resp_field(RESP_SLVERR);
            rsp_rdata      <= '0;
            state          <= ST_RSP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        if (cmd_write) begin
                            m3_axi_awvalid <= 1'b1;
                            m3_axi_wvalid  <= 1'b1;
                            state          <= ST_WR_AD;
                        end else begin
                            m3_axi_arvalid <= 1'b1;
                            state          <= ST_RD_A;
                        end
                    end
                end
                ST_WR_AD: begin
                    if (aw_hs) m3_axi_awvalid <= 1'b0;
                    if (w_hs)  m3_axi_wvalid  <= 1'b0;
                    if (ad_done) begin
                        m3_axi_bready <= 1'b1;
                        state         <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (b_hs) begin
                        m3_axi_bready <= 1'b0;
                        rsp_resp      <= resp_field(m3_axi_bresp[1:0]);
                        rsp_rdata     <= '0;
                        rsp_timeout   <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RSP;
                    end
                end
                ST_RD_A: begin
                    if (ar_hs) begin
                        m3_axi_arvalid <= 1'b0;
                        m3_axi_rready  <= 1'b1;
                        state          <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    if (r_hs) begin
                        m3_axi_rready <= 1'b0;
                        rsp_rdata     <= m3_axi_rdata;
                        rsp_resp      <= resp_field(m3_axi_rresp[1:0]);
                        rsp_timeout   <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// tb/tb_axi_lite_master_engine.sv - directed bench with a configurable register-slave stub
module tb_axi_lite_master_engine;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  bresp, rresp;

    axi_lite_master_engine #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (8),
        .RESP_WIDTH     (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .s3_axi_aclk    (clk),
        .s3_axi_aresetn (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .m3_axi_awaddr  (awaddr),
        .m3_axi_awvalid (awvalid),
        .m3_axi_awready (awready),
        .m3_axi_wdata   (wdata),
        .m3_axi_wstrb   (wstrb),
        .m3_axi_wvalid  (wvalid),
        .m3_axi_wready  (wready),
        .m3_axi_bresp   (bresp),
        .m3_axi_bvalid  (bvalid),
        .m3_axi_bready  (bready),
        .m3_axi_araddr  (araddr),
        .m3_axi_arvalid (arvalid),
        .m3_axi_arready (arready),
        .m3_axi_rdata   (rdata),
        .m3_axi_rresp   (rresp),
        .m3_axi_rvalid  (rvalid),
        .m3_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave stub: readies rise after a programmable number of waiting cycles.
    int          aw_delay, w_delay;
    bit          b_never;
    logic [1:0]  bresp_code;
    int          aw_cnt, w_cnt, cyc, acc_cyc, aw_cyc, w_cyc, write_count, aw_only_cnt;
    logic [31:0] mem [64];
    logic        aw_got, w_got;
    logic [5:0]  aw_idx, idx_now;
    logic [31:0] w_data, data_now;
    logic [3:0]  w_strb, strb_now;
    logic        aw_hs, w_hs, do_write, unused_tb;

    assign awready   = (aw_cnt >= aw_delay);
    assign wready    = (w_cnt >= w_delay);
    assign arready   = 1'b1;
    assign bresp     = {1'b0, bresp_code};
    assign rresp     = 3'b000;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign idx_now   = aw_hs ? awaddr[7:2] : aw_idx;
    assign data_now  = w_hs ? wdata : w_data;
    assign strb_now  = w_hs ? wstrb : w_strb;
    assign do_write  = (aw_got | aw_hs) & (w_got | w_hs);
    assign unused_tb = ^{awaddr[1:0], araddr[1:0]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; cyc <= 0; acc_cyc <= 0; aw_cyc <= 0; w_cyc <= 0;
            write_count <= 0; aw_got <= 1'b0; w_got <= 1'b0; aw_idx <= '0;
            w_data <= '0; w_strb <= '0; bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            cyc    <= cyc + 1;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (cmd_valid && cmd_ready) acc_cyc <= cyc;
            if (aw_hs) aw_cyc <= cyc;
            if (w_hs) w_cyc <= cyc;
            if (bvalid && bready) bvalid <= 1'b0;
            if (do_write) begin
                for (int b = 0; b < 4; b++)
                    if (strb_now[b]) mem[idx_now][8*b +: 8] <= data_now[8*b +: 8];
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
                write_count <= write_count + 1;
                bvalid      <= !b_never;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_idx <= awaddr[7:2]; end
                if (w_hs) begin w_got <= 1'b1; w_data <= wdata; w_strb <= wstrb; end
            end
            if (arvalid && arready) begin
                rdata  <= mem[araddr[7:2]];
                rvalid <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    initial aw_only_cnt = 0;
    always @(negedge clk) if (awvalid && !wvalid) aw_only_cnt <= aw_only_cnt + 1;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_arrives", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic xact(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
        issue(wr, a, d, s);
        wait_rsp(lat);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    int lat, wc0, ao0;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        aw_delay = 0; w_delay = 0; b_never = 1'b0; bresp_code = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);
        check("reset_readies", {29'd0, bready, rready, rsp_timeout}, 32'd0);

        // Zero-wait write: handshakes at N+1, response registered by N+2.
        xact(1'b1, 8'h00, 32'd25, 4'hF, lat);
        check("wr0_latency", lat, 32'd2);
        check("wr0_aw_hs_cycle", aw_cyc - acc_cyc, 32'd1);
        check("wr0_w_hs_cycle", w_cyc - acc_cyc, 32'd1);
        check("wr0_resp", {29'd0, rsp_resp}, 32'd0);
        check("wr0_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("wr0_rdata", rsp_rdata, 32'd0);
        check("wr0_busy", {31'd0, busy}, 32'd1);
        check("wr0_mem", mem[0], 32'd25);
        consume();
        check("wr0_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

        xact(1'b1, 8'h04, 32'd34, 4'hF, lat);
        check("wr4_resp", {29'd0, rsp_resp}, 32'd0);
        consume();
        xact(1'b0, 8'h00, 32'd0, 4'h0, lat);
        check("rd0_latency", lat, 32'd2);
        check("rd0_rdata", rsp_rdata, 32'd25);
        check("rd0_resp", {29'd0, rsp_resp}, 32'd0);
        consume();

        // Response back-pressure; a command offered meanwhile must be ignored.
        xact(1'b0, 8'h04, 32'd0, 4'h0, lat);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00;
        for (int k = 0; k < 5; k++) begin
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'd34);
            check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("stall_no_arvalid", {31'd0, arvalid}, 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        consume();
        check("stall_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

        // wready three cycles ahead of awready.
        aw_delay = 3; w_delay = 0;
        wc0 = write_count; ao0 = aw_only_cnt;
        xact(1'b1, 8'h10, 32'hA5A5_0001, 4'hF, lat);
        check("w_first_gap", aw_cyc - w_cyc, 32'd3);
        check("w_first_aw_held", aw_only_cnt - ao0, 32'd3);
        check("w_first_one_write", write_count - wc0, 32'd1);
        check("w_first_mem", mem[4], 32'hA5A5_0001);
        check("w_first_latency", lat, 32'd5);
        consume();

        // awready three cycles ahead of wready, partial strobes.
        aw_delay = 0; w_delay = 3;
        wc0 = write_count;
        xact(1'b1, 8'h14, 32'h1234_5678, 4'b0101, lat);
        check("aw_first_gap", w_cyc - aw_cyc, 32'd3);
        check("aw_first_one_write", write_count - wc0, 32'd1);
        check("aw_first_mem_strb", mem[5], 32'h0034_0078);
        check("aw_first_latency", lat, 32'd5);
        consume();
        w_delay = 0;

        bresp_code = 2'b11;
        xact(1'b1, 8'h18, 32'd9, 4'hF, lat);
        check("decerr_resp", {29'd0, rsp_resp}, 32'd3);
        check("decerr_timeout", {31'd0, rsp_timeout}, 32'd0);
        consume();
        bresp_code = 2'b00;

        // Missing write response: 16-cycle wait in WR_B, then abort.
        b_never = 1'b1;
        xact(1'b1, 8'h1C, 32'd1, 4'hF, lat);
        check("tmo_latency", lat, 32'd17);
        check("tmo_flag", {31'd0, rsp_timeout}, 32'd1);
        check("tmo_resp", {29'd0, rsp_resp}, 32'd2);
        check("tmo_rdata", rsp_rdata, 32'd0);
        check("tmo_bready_low", {31'd0, bready}, 32'd0);
        consume();
        check("tmo_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("tmo_idle_busy", {31'd0, busy}, 32'd0);
        check("tmo_flag_cleared", {31'd0, rsp_timeout}, 32'd0);
        b_never = 1'b0;

        // Reset pulse while the write address is pending.
        aw_delay = 5; w_delay = 5;
        issue(1'b1, 8'h0C, 32'h55, 4'hF);
        check("pre_rst_valids", {30'd0, awvalid, wvalid}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valids", {30'd0, awvalid, wvalid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; aw_delay = 0; w_delay = 0;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        xact(1'b1, 8'h08, 32'd7, 4'hF, lat);
        check("post_rst_latency", lat, 32'd2);
        check("post_rst_resp", {29'd0, rsp_resp}, 32'd0);
        check("post_rst_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("post_rst_mem8", mem[2], 32'd7);
        check("post_rst_mem_c_untouched", mem[3], 32'd0);
        check("post_rst_write_count", write_count, 32'd1);
        consume();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
